// File: rtl/audio_pkg.sv
// Shared constants and types for the audio sample streamer.
package audio_pkg;

    localparam int SAMPLE_W = 8;
    localparam logic [SAMPLE_W-1:0] SILENCE = 8'h80;
    localparam int DEF_BLOCK_BYTES = 512;

    typedef enum logic {
        REQ_IDLE = 1'b0,
        REQ_WAIT = 1'b1
    } req_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock FIFO with combinational head read, full/empty flags and an
// occupancy counter spanning 0..DEPTH. Pointers wrap naturally at DEPTH.
module sample_fifo
    import audio_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Qualify requests against the flags and advance pointers and occupancy.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards any stored data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/audio_sample_streamer.sv
// Rate-converting byte buffer feeding the PWM stage: accepts SD bytes into a
// FIFO, emits one sample per audio period, and requests refills at low water.
//
// Request FSM
//   state    | meaning
//   REQ_IDLE | no block outstanding; request when fill <= LOW_WATER and enabled
//   REQ_WAIT | block requested; counting accepted bytes up to BLOCK_BYTES
module audio_sample_streamer
    import audio_pkg::*;
#(
    parameter int TICKS_PER_SAMPLE = 2268,
    parameter int DEPTH            = 1024,
    parameter int BLOCK_BYTES      = DEF_BLOCK_BYTES,
    parameter int LOW_WATER        = 512
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [SAMPLE_W-1:0]      byte_in,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    output logic                     block_req,
    output logic [SAMPLE_W-1:0]      music_data,
    output logic                     sample_strobe,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int TW = $clog2(TICKS_PER_SAMPLE);
    localparam int FW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(BLOCK_BYTES) + 1;
    localparam logic [TW-1:0] TICK_LAST   = TW'(TICKS_PER_SAMPLE - 1);
    localparam logic [FW-1:0] LOW_WATER_C = FW'(LOW_WATER);
    localparam logic [BW-1:0] BLOCK_C     = BW'(BLOCK_BYTES);

    logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
    logic                tick;
    logic                push, pop;
    logic [SAMPLE_W-1:0] fifo_head;
    logic                fifo_full, fifo_empty;
    logic [FW-1:0]       fifo_count;

    logic [SAMPLE_W-1:0] music_data_q, music_data_d;
    logic                strobe_q, strobe_d;
    logic                underrun_q, underrun_d;

    req_state_t          state_q, state_d;
    logic [BW-1:0]       byte_cnt_q, byte_cnt_d;
    logic                block_req_q, block_req_d;

    assign byte_ready    = !fifo_full;
    assign push          = byte_valid && byte_ready;
    assign fill_level    = fifo_count;
    assign music_data    = music_data_q;
    assign sample_strobe = strobe_q;
    assign underrun      = underrun_q;
    assign block_req     = block_req_q;

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (byte_in),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Sample-period counter: held at zero while disabled, fires on its last count.
    always_comb begin
        tick       = enable && (tick_cnt_q == TICK_LAST);
        tick_cnt_d = (!enable || tick) ? '0 : tick_cnt_q + TW'(1);
    end

    // Output sample path: pop on tick, strobe every tick, latch underrun on empty tick.
    always_comb begin
        pop          = tick && !fifo_empty;
        music_data_d = pop ? fifo_head : music_data_q;
        strobe_d     = tick;
        underrun_d   = underrun_q || (tick && fifo_empty);
    end

    // Sample path and tick counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q   <= '0;
            music_data_q <= SILENCE;
            strobe_q     <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            music_data_q <= music_data_d;
            strobe_q     <= strobe_d;
            underrun_q   <= underrun_d;
        end
    end

    // Request FSM state register, including the registered block_req pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= REQ_IDLE;
            byte_cnt_q  <= '0;
            block_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            block_req_q <= block_req_d;
        end
    end

    // Request FSM next state: issue at low water, then count the block in.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        case (state_q)
            REQ_IDLE: begin
                if (enable && (fifo_count <= LOW_WATER_C)) begin
                    state_d    = REQ_WAIT;
                    byte_cnt_d = '0;
                end
            end
            REQ_WAIT: begin
                if (push) begin
                    byte_cnt_d = byte_cnt_q + BW'(1);
                    if (byte_cnt_d == BLOCK_C) begin
                        state_d = REQ_IDLE;
                    end
                end
            end
            default: begin
                state_d    = REQ_IDLE;
                byte_cnt_d = '0;
            end
        endcase
    end

    // Request FSM output: one registered pulse on the IDLE to WAIT transition.
    always_comb begin
        block_req_d = (state_q == REQ_IDLE) && (state_d == REQ_WAIT);
    end

endmodule
